// File: rtl/pixel_window3x3_param.sv
// 3x3 sliding-window generator over a raster pixel stream, with two line buffers.
// Optional RGB565->RGB888 output expansion is enabled by defining PIXWIN_RGB888_EN.
module pixel_window3x3_param #(
  parameter int DW    = 16,
  parameter int IMG_W = 480,
  parameter int IMG_H = 272,
  parameter int XW    = $clog2(IMG_W),
  parameter int YW    = $clog2(IMG_H),
`ifdef PIXWIN_RGB888_EN
  localparam int OW   = 24
`else
  localparam int OW   = DW
`endif
) (
  input  logic          iClk,
  input  logic          wRsn,
  input  logic          wEnClk,
  input  logic          wFgIBufValid,
  input  logic [DW-1:0] wIBufRdDt,
  input  logic          wFrameStart,
  output logic          wFgPixelValid,
  output logic [OW-1:0] wPixel00,
  output logic [OW-1:0] wPixel01,
  output logic [OW-1:0] wPixel02,
  output logic [OW-1:0] wPixel10,
  output logic [OW-1:0] wPixel11,
  output logic [OW-1:0] wPixel12,
  output logic [OW-1:0] wPixel20,
  output logic [OW-1:0] wPixel21,
  output logic [OW-1:0] wPixel22,
  output logic [XW-1:0] wWinX,
  output logic [YW-1:0] wWinY,
  output logic          wConvolDone
);

`ifdef PIXWIN_RGB888_EN
  if (DW != 16) begin : g_dw_check
    $error("PIXWIN_RGB888_EN requires DW = 16");
  end
`endif

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  logic          accept;
  logic [XW-1:0] x, cx;
  logic [YW-1:0] y, cy;
  logic [DW-1:0] lb0 [IMG_W];
  logic [DW-1:0] lb1 [IMG_W];
  logic [DW-1:0] top, mid;
  logic [OW-1:0] win [3][3];

  function automatic logic [OW-1:0] expand(input logic [DW-1:0] p);
`ifdef PIXWIN_RGB888_EN
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
`else
    return p;
`endif
  endfunction

  assign accept = wEnClk & wFgIBufValid;

  // A frame start coincident with an accept makes that pixel (0,0).
  always_comb begin
    cx = wFrameStart ? '0 : x;
    cy = wFrameStart ? '0 : y;
  end

  always_ff @(posedge iClk or negedge wRsn) begin
    if (!wRsn) begin
      x <= '0;
      y <= '0;
    end else if (accept) begin
      if (cx == X_LAST) begin
        x <= '0;
        y <= (cy == Y_LAST) ? '0 : cy + 1'b1;
      end else begin
        x <= cx + 1'b1;
        y <= cy;
      end
    end else if (wFrameStart) begin
      x <= '0;
      y <= '0;
    end
  end

  assign top = lb1[cx];
  assign mid = lb0[cx];

  // Line buffers are never cleared; stale contents are masked by the x/y >= 2 gate.
  always_ff @(posedge iClk) begin
    if (accept) begin
      lb1[cx] <= mid;
      lb0[cx] <= wIBufRdDt;
    end
  end

  always_ff @(posedge iClk or negedge wRsn) begin
    if (!wRsn) begin
      for (int unsigned r = 0; r < 3; r++)
        for (int unsigned c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else if (accept) begin
      for (int unsigned r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= expand(top);
      win[1][2] <= expand(mid);
      win[2][2] <= expand(wIBufRdDt);
    end
  end

  always_ff @(posedge iClk or negedge wRsn) begin
    if (!wRsn) begin
      wFgPixelValid <= 1'b0;
      wConvolDone   <= 1'b0;
      wWinX         <= '0;
      wWinY         <= '0;
    end else begin
      wFgPixelValid <= 1'b0;
      wConvolDone   <= 1'b0;
      if (accept && cx >= XW'(2) && cy >= YW'(2)) begin
        wFgPixelValid <= 1'b1;
        wConvolDone   <= (cx == X_LAST) && (cy == Y_LAST);
        wWinX         <= cx - 1'b1;
        wWinY         <= cy - 1'b1;
      end
    end
  end

  assign wPixel00 = win[0][0];
  assign wPixel01 = win[0][1];
  assign wPixel02 = win[0][2];
  assign wPixel10 = win[1][0];
  assign wPixel11 = win[1][1];
  assign wPixel12 = win[1][2];
  assign wPixel20 = win[2][0];
  assign wPixel21 = win[2][1];
  assign wPixel22 = win[2][2];

endmodule
